// File: rtl/sd_sector_sink.sv
// ----------------------------------------------------------------------------
// sd_sector_sink
//
// Consumes the byte stream of one SD sector read, packs byte pairs into
// 16-bit words and writes them to the frame-buffer RAM write port. It also
// owns the sector address the SPI reader uses for its next CMD17. That
// address walks SECTORS_PER_FRAME sectors starting at BASE_SECTOR and then
// wraps back to BASE_SECTOR.
//
// Ports
//   MasterCLK        in   system clock, the only clock
//   Reset            in   synchronous, active-high reset
//   SD_Data          in   byte from the reader, stable around each strobe rise
//   SD_DataValid     in   reader data window (asynchronous to MasterCLK)
//   SD_DataStrobe    in   reader byte strobe, rising edge = new byte (async)
//   SD_SectorAddress out  sector address for the reader's next read
//   WriteAddress     out  frame-buffer word address
//   WriteData        out  packed word, even byte in [7:0], odd byte in [15:8]
//   WriteEnable      out  one-cycle write pulse
//   SectorDone       out  one-cycle pulse when a full sector has been taken
//   FrameDone        out  one-cycle pulse with the last SectorDone of a frame
//   ShortSector      out  one-cycle pulse when the data window closes early
//   Overflow         out  sticky: a byte arrived after the sector was full
// ----------------------------------------------------------------------------
module sd_sector_sink #(
    parameter int unsigned BYTES_PER_SECTOR  = 512,
    parameter int unsigned SECTORS_PER_FRAME = 75,
    parameter int unsigned BASE_SECTOR       = 0,
    parameter int unsigned ADDR_WIDTH        = 15
) (
    input  logic                  MasterCLK,
    input  logic                  Reset,
    input  logic [7:0]            SD_Data,
    input  logic                  SD_DataValid,
    input  logic                  SD_DataStrobe,
    output logic [15:0]           SD_SectorAddress,
    output logic [ADDR_WIDTH-1:0] WriteAddress,
    output logic [15:0]           WriteData,
    output logic                  WriteEnable,
    output logic                  SectorDone,
    output logic                  FrameDone,
    output logic                  ShortSector,
    output logic                  Overflow
);

    // Byte count must reach BYTES_PER_SECTOR itself, hence the +1.
    localparam int unsigned CountWidth = $clog2(BYTES_PER_SECTOR + 1);
    localparam int unsigned IndexWidth =
        (SECTORS_PER_FRAME > 1) ? $clog2(SECTORS_PER_FRAME) : 1;

    localparam logic [CountWidth-1:0] LastByte       = CountWidth'(BYTES_PER_SECTOR - 1);
    localparam logic [IndexWidth-1:0] LastSector     = IndexWidth'(SECTORS_PER_FRAME - 1);
    localparam logic [ADDR_WIDTH-1:0] WordsPerSector = ADDR_WIDTH'(BYTES_PER_SECTOR / 2);
    localparam logic [15:0]           BaseSector     = 16'(BASE_SECTOR);

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StComplete,
        StDrain
    } stateType;

    // ------------------------------------------------------------------
    // Input synchronisers: two flops for metastability, one history flop
    // for edge detection.
    // ------------------------------------------------------------------
    logic strobeSync1;
    logic strobeSync2;
    logic strobeHist;
    logic validSync1;
    logic validSync2;
    logic validHist;

    always_ff @(posedge MasterCLK) begin
        if (Reset) begin
            strobeSync1 <= 1'b0;
            strobeSync2 <= 1'b0;
            strobeHist  <= 1'b0;
            validSync1  <= 1'b0;
            validSync2  <= 1'b0;
            validHist   <= 1'b0;
        end else begin
            strobeSync1 <= SD_DataStrobe;
            strobeSync2 <= strobeSync1;
            strobeHist  <= strobeSync2;
            validSync1  <= SD_DataValid;
            validSync2  <= validSync1;
            validHist   <= validSync2;
        end
    end

    logic strobeEdge;
    logic validRise;

    assign strobeEdge = strobeSync2 & ~strobeHist;
    assign validRise  = validSync2 & ~validHist;

    // ------------------------------------------------------------------
    // Sector state machine with registered outputs.
    // wordBase tracks sectorIndex * words-per-sector incrementally so the
    // write address needs only an adder, not a multiplier.
    // ------------------------------------------------------------------
    stateType                state;
    logic [CountWidth-1:0]   byteCount;
    logic [IndexWidth-1:0]   sectorIndex;
    logic [ADDR_WIDTH-1:0]   wordBase;
    logic [7:0]              lowByte;

    always_ff @(posedge MasterCLK) begin
        if (Reset) begin
            state            <= StIdle;
            byteCount        <= '0;
            sectorIndex      <= '0;
            wordBase         <= '0;
            lowByte          <= 8'h00;
            SD_SectorAddress <= BaseSector;
            WriteAddress     <= '0;
            WriteData        <= 16'h0000;
            WriteEnable      <= 1'b0;
            SectorDone       <= 1'b0;
            FrameDone        <= 1'b0;
            ShortSector      <= 1'b0;
            Overflow         <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            WriteEnable <= 1'b0;
            SectorDone  <= 1'b0;
            FrameDone   <= 1'b0;
            ShortSector <= 1'b0;

            case (state)
                StIdle: begin
                    // Strobes seen here are ignored; only a fresh data
                    // window opens a sector.
                    byteCount <= '0;
                    if (validRise) begin
                        state <= StFill;
                    end
                end

                StFill: begin
                    // A byte on the same cycle as the window closing is
                    // still taken; the short-sector check then happens on
                    // the following cycle.
                    if (strobeEdge) begin
                        if (!byteCount[0]) begin
                            lowByte <= SD_Data;
                        end else begin
                            WriteData    <= {SD_Data, lowByte};
                            WriteAddress <= wordBase + ADDR_WIDTH'(byteCount >> 1);
                            WriteEnable  <= 1'b1;
                        end
                        byteCount <= byteCount + CountWidth'(1);
                        if (byteCount == LastByte) begin
                            state <= StComplete;
                        end
                    end else if (!validSync2) begin
                        // Window closed early: sector index and address
                        // are kept so the same sector is fetched again.
                        ShortSector <= 1'b1;
                        byteCount   <= '0;
                        state       <= StIdle;
                    end
                end

                StComplete: begin
                    SectorDone <= 1'b1;
                    if (sectorIndex == LastSector) begin
                        sectorIndex      <= '0;
                        wordBase         <= '0;
                        SD_SectorAddress <= BaseSector;
                        FrameDone        <= 1'b1;
                    end else begin
                        sectorIndex      <= sectorIndex + IndexWidth'(1);
                        wordBase         <= wordBase + WordsPerSector;
                        SD_SectorAddress <= SD_SectorAddress + 16'd1;
                    end
                    // The sector is already full, so any byte here is extra.
                    if (strobeEdge) begin
                        Overflow <= 1'b1;
                    end
                    state <= StDrain;
                end

                StDrain: begin
                    // Surplus bytes are dropped; only the sticky flag records them.
                    if (strobeEdge) begin
                        Overflow <= 1'b1;
                    end
                    if (!validSync2) begin
                        state <= StIdle;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_sector_sink.sv
// ----------------------------------------------------------------------------
// tb_sd_sector_sink
//
// Self-checking bench for sd_sector_sink. Expected frame-buffer writes are
// pushed to a scoreboard queue as bytes are driven and popped when the DUT
// pulses WriteEnable. Sector-level outcomes come from a table of records;
// reset-mid-sector and frame wrap are written out as explicit sequences.
// A short frame (20 sectors) and a non-zero base sector keep the run short
// while still exercising the wrap and base-address paths.
// ----------------------------------------------------------------------------
module tb_sd_sector_sink;

    localparam int unsigned Bps  = 512;
    localparam int unsigned Spf  = 20;
    localparam int unsigned Base = 300;
    localparam int unsigned Aw   = 15;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic [7:0]    sdData   = 8'h00;
    logic          sdValid  = 1'b0;
    logic          sdStrobe = 1'b0;

    logic [15:0]   sectorAddress;
    logic [Aw-1:0] writeAddress;
    logic [15:0]   writeData;
    logic          writeEnable;
    logic          sectorDone;
    logic          frameDone;
    logic          shortSector;
    logic          overflow;

    always #5 clk = ~clk;

    sd_sector_sink #(
        .BYTES_PER_SECTOR (Bps),
        .SECTORS_PER_FRAME(Spf),
        .BASE_SECTOR      (Base),
        .ADDR_WIDTH       (Aw)
    ) dut (
        .MasterCLK       (clk),
        .Reset           (rst),
        .SD_Data         (sdData),
        .SD_DataValid    (sdValid),
        .SD_DataStrobe   (sdStrobe),
        .SD_SectorAddress(sectorAddress),
        .WriteAddress    (writeAddress),
        .WriteData       (writeData),
        .WriteEnable     (writeEnable),
        .SectorDone      (sectorDone),
        .FrameDone       (frameDone),
        .ShortSector     (shortSector),
        .Overflow        (overflow)
    );

    typedef struct packed {
        logic [Aw-1:0] addr;
        logic [15:0]   data;
    } writeRec;

    typedef struct {
        int          strobes;
        logic        simul;        // valid falls together with last strobe
        logic [7:0]  seed;
        int          expWrites;
        int          expSectorDone;
        int          expShort;
        logic        expOverflow;
        logic [15:0] expSectorAddr;
    } vecRec;

    writeRec expQ[$];
    int      nChecks = 0;
    int      nFail   = 0;
    int      sdCnt   = 0;
    int      fdCnt   = 0;
    int      shCnt   = 0;
    int      wrCnt   = 0;

    // Reference model state.
    int         modelSector = 0;
    int         byteIdx     = 0;
    logic [7:0] lowModel    = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One clock: sample outputs on the falling edge, then step past the
    // rising edge so the caller can drive the next inputs.
    task automatic tick();
        writeRec e;
        @(negedge clk);
        if (writeEnable === 1'b1) begin
            wrCnt++;
            if (expQ.size() == 0) begin
                nChecks++;
                nFail++;
                $display("FAIL wr_unexpected: got write addr %0d data 0x%0h, required no write",
                         writeAddress, writeData);
            end else begin
                e = expQ.pop_front();
                check("wr_addr", 32'(writeAddress), 32'(e.addr));
                check("wr_data", 32'(writeData), 32'(e.data));
            end
        end
        if (sectorDone === 1'b1) sdCnt++;
        if (shortSector === 1'b1) shCnt++;
        if (frameDone === 1'b1) begin
            fdCnt++;
            check("frame_with_sector", 32'(sectorDone), 32'd1);
        end
        @(posedge clk);
        #1;
    endtask

    // One byte: strobe high for a cycle, data held for three cycles so it is
    // still stable when the synchronised edge reaches the DUT.
    task automatic sendByte(input logic [7:0] d, input logic dropValid);
        writeRec e;
        sdData   = d;
        sdStrobe = 1'b1;
        if (dropValid) sdValid = 1'b0;
        if (byteIdx < int'(Bps)) begin
            if (byteIdx % 2 == 0) begin
                lowModel = d;
            end else begin
                e.addr = Aw'(modelSector * int'(Bps / 2) + byteIdx / 2);
                e.data = {d, lowModel};
                expQ.push_back(e);
            end
        end
        byteIdx++;
        tick();
        sdStrobe = 1'b0;
        tick();
        tick();
    endtask

    task automatic runSector(input int strobes, input logic simul, input logic [7:0] seed);
        byteIdx = 0;
        sdValid = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < strobes; i++) begin
            sendByte(8'(i) ^ seed, simul && (i == strobes - 1));
        end
        sdValid = 1'b0;
        repeat (6) tick();
        if (strobes >= int'(Bps)) modelSector = (modelSector + 1) % int'(Spf);
        check("wr_queue_drained", 32'(expQ.size()), 32'd0);
    endtask

    vecRec vecs[5];

    initial begin
        int sd0;
        int fd0;
        int sh0;
        int wr0;

        vecs[0] = '{512, 1'b0, 8'h00, 256, 1, 0, 1'b0, 16'(Base + 1)};  // full sector
        vecs[1] = '{301, 1'b0, 8'h5A, 150, 0, 1, 1'b0, 16'(Base + 1)};  // short sector
        vecs[2] = '{512, 1'b0, 8'hC3, 256, 1, 0, 1'b0, 16'(Base + 2)};  // reread same sector
        vecs[3] = '{513, 1'b0, 8'h11, 256, 1, 0, 1'b1, 16'(Base + 3)};  // overflow
        vecs[4] = '{512, 1'b1, 8'h7E, 256, 1, 0, 1'b1, 16'(Base + 4)};  // last byte + valid fall

        // Power-on reset.
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_sector_addr", 32'(sectorAddress), 32'(Base));
        check("rst_write_addr", 32'(writeAddress), 32'd0);
        check("rst_write_data", 32'(writeData), 32'd0);
        check("rst_write_en", 32'(writeEnable), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_pulses", 32'(sdCnt + fdCnt + shCnt), 32'd0);

        // Table-driven sectors.
        for (int v = 0; v < 5; v++) begin
            sd0 = sdCnt;
            fd0 = fdCnt;
            sh0 = shCnt;
            wr0 = wrCnt;
            runSector(vecs[v].strobes, vecs[v].simul, vecs[v].seed);
            check("vec_writes", 32'(wrCnt - wr0), 32'(vecs[v].expWrites));
            check("vec_sector_done", 32'(sdCnt - sd0), 32'(vecs[v].expSectorDone));
            check("vec_frame_done", 32'(fdCnt - fd0), 32'd0);
            check("vec_short", 32'(shCnt - sh0), 32'(vecs[v].expShort));
            check("vec_overflow", 32'(overflow), 32'(vecs[v].expOverflow));
            check("vec_sector_addr", 32'(sectorAddress), 32'(vecs[v].expSectorAddr));
        end

        // Reset in the middle of a sector: 100 bytes, then a one-cycle reset.
        byteIdx = 0;
        sdValid = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 100; i++) sendByte(8'(i) ^ 8'h33, 1'b0);
        repeat (3) tick();
        check("mid_writes_drained", 32'(expQ.size()), 32'd0);
        sd0 = sdCnt;
        fd0 = fdCnt;
        sh0 = shCnt;
        rst     = 1'b1;
        sdValid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("mid_rst_sector_addr", 32'(sectorAddress), 32'(Base));
        check("mid_rst_write_addr", 32'(writeAddress), 32'd0);
        check("mid_rst_write_data", 32'(writeData), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        repeat (6) tick();
        check("mid_rst_no_pulses", 32'((sdCnt - sd0) + (fdCnt - fd0) + (shCnt - sh0)), 32'd0);
        modelSector = 0;

        // Frame wrap: sectors 0..Spf-1 back to back.
        for (int s = 0; s < int'(Spf); s++) begin
            sd0 = sdCnt;
            fd0 = fdCnt;
            runSector(int'(Bps), 1'b0, 8'(s * 7));
            check("frm_sector_done", 32'(sdCnt - sd0), 32'd1);
            check("frm_frame_done", 32'(fdCnt - fd0), (s == int'(Spf) - 1) ? 32'd1 : 32'd0);
            check("frm_sector_addr", 32'(sectorAddress),
                  (s == int'(Spf) - 1) ? 32'(Base) : 32'(Base + s + 1));
        end

        // Next sector after the wrap starts again at word address 0.
        sh0 = shCnt;
        wr0 = wrCnt;
        runSector(20, 1'b0, 8'hA5);
        check("wrap_writes", 32'(wrCnt - wr0), 32'd10);
        check("wrap_short", 32'(shCnt - sh0), 32'd1);
        check("wrap_sector_addr", 32'(sectorAddress), 32'(Base));

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/sd_sector_sink.md
Name: sd_sector_sink

Overview:
Downstream consumer of the SD SPI sector reader. It receives the byte stream of a 512-byte sector read and packs the bytes into 16-bit words. It writes those words into the video frame-buffer RAM write port. It also generates the sector address the reader uses for its next CMD17, walking through a fixed number of sectors per frame and then wrapping.

Parameters:
BYTES_PER_SECTOR, 512, data bytes per sector read; must be even.
SECTORS_PER_FRAME, 75, sectors per frame (160x120x16bpp).
BASE_SECTOR, 0, first sector address of the frame on the card.
ADDR_WIDTH, 15, frame-buffer word address width; must hold SECTORS_PER_FRAME*BYTES_PER_SECTOR/2 - 1.

Ports:
MasterCLK  input  1  system clock; the only clock.
Reset  input  1  synchronous, active-high reset.
SD_Data  input  8  byte from the SD reader; stable for a full byte period around each strobe rise.
SD_DataValid  input  1  reader's data-window enable; high during sector data transfer.
SD_DataStrobe  input  1  reader's byte strobe; a rising edge marks a new byte.
SD_SectorAddress  output  16  sector address for the reader's next read.
WriteAddress  output  ADDR_WIDTH  frame-buffer word address.
WriteData  output  16  packed word: even byte in [7:0], odd byte in [15:8].
WriteEnable  output  1  one-cycle write pulse.
SectorDone  output  1  one-cycle pulse when a sector completes.
FrameDone  output  1  one-cycle pulse when the last sector of a frame completes.
ShortSector  output  1  one-cycle pulse when a sector is aborted early.
Overflow  output  1  sticky flag: a byte arrived beyond BYTES_PER_SECTOR.

Behaviour:
- One clock (MasterCLK); reset is synchronous and active-high (Reset). All logic runs on MasterCLK rising edge.
- Reset values: SD_SectorAddress=BASE_SECTOR; WriteAddress=0; WriteData=0; WriteEnable, SectorDone, FrameDone, ShortSector, Overflow = 0; state=IDLE; byte count=0; sector index=0.
- Input sync: SD_DataStrobe and SD_DataValid each pass through 2 sync FFs plus 1 history FF.
  - strobe_edge = sync2 & ~hist.
  - valid uses its sync2 value.
  - SD_Data is sampled on the strobe_edge cycle; no sync is needed because data is stable for 8 SPI clocks.
- Latency: strobe high at MasterCLK edge N gives strobe_edge at N+2. For an odd byte, WriteEnable is high during N+3 with WriteAddress/WriteData valid.
- Byte handling:
  - Even byte index: latch into low half; no write.
  - Odd byte index: form the word and pulse WriteEnable.
  - WriteAddress = sector_index*(BYTES_PER_SECTOR/2) + byte_index>>1.
- States:
  - IDLE: byte count=0. valid rising (synced) -> FILL. A strobe_edge in IDLE is ignored.
  - FILL, on strobe_edge:
    - accept the byte and increment byte count (10-bit, range 0..BYTES_PER_SECTOR).
    - if this is byte BYTES_PER_SECTOR-1 -> COMPLETE.
  - FILL, valid low with no strobe_edge that cycle:
    - pulse ShortSector, drop any pending even byte, -> IDLE.
    - SD_SectorAddress and sector index are unchanged, so the same sector is reread and its words are overwritten.
  - COMPLETE (1 cycle):
    - pulse SectorDone and increment sector index.
    - SD_SectorAddress = SD_SectorAddress+1 (16-bit wrap).
    - if sector index was SECTORS_PER_FRAME-1: sector index=0, SD_SectorAddress=BASE_SECTOR, pulse FrameDone in the same cycle.
    - -> DRAIN.
  - DRAIN: wait for valid low -> IDLE. Any strobe_edge here sets Overflow (sticky until Reset); the byte is discarded, with no write and no count change.
- Simultaneous events:
  - strobe_edge and valid-low in the same FILL cycle: the byte is accepted first. If it is the last byte, the sector completes normally; otherwise ShortSector fires the next cycle.
  - valid already low on entering DRAIN: exit to IDLE the next cycle.
- SD_SectorAddress changes only in COMPLETE, which happens while valid is high, so it is stable before the reader's next valid rise.
- Reset mid-FILL or mid-DRAIN: immediate return to reset values; no SectorDone, FrameDone or ShortSector pulse.

Test Plan:
- Full sector: valid high, 512 strobes with data=byte_index[7:0] -> 256 WriteEnable pulses at addresses 0..255. Word k = {2k+1, 2k}. One SectorDone. SD_SectorAddress 0->1. Overflow=0.
- Frame wrap: 75 consecutive full sectors -> last sector writes addresses 18944..19199. FrameDone and SectorDone coincide. SD_SectorAddress returns to 0. The next sector writes from address 0.
- Short sector: valid drops after 301 strobes -> 150 writes, one ShortSector pulse, SD_SectorAddress unchanged. A following full sector rewrites the same addresses and gives one SectorDone.
- Overflow: 513 strobes in one valid window -> 256 writes, SectorDone once. Overflow goes to 1 at the 513th strobe and stays 1 until Reset.
- Simultaneous: the 512th strobe and valid fall arrive on the same synced cycle -> final write occurs, SectorDone=1, ShortSector=0.
- Reset mid-sector: Reset for 1 cycle after 100 strobes -> all outputs return to reset values with no pulses. The next sector starts at WriteAddress 0 with SD_SectorAddress=BASE_SECTOR.
